// File: rtl/frame_uart_tx_pkg.sv
// frame_uart_tx_pkg: shared FSM encodings and UART framing constants
package frame_uart_tx_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
  localparam int CLK_DIV_DEF = 434;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = FRAME_BITS - 2;
endpackage

// File: rtl/frame_uart_tx_byte_fifo.sv
// frame_uart_tx_byte_fifo: register FIFO with head byte visible on rdata whenever not empty
module frame_uart_tx_byte_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [7:0]        wdata,
  input  logic              rd,
  output logic [7:0]        rdata,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wp, rp;
  logic push, pop;
  assign full  = level == (ADDR_W+1)'(2**ADDR_W);
  assign empty = level == '0;
  assign push  = wr & ~full;
  assign pop   = rd & ~empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= wdata;
endmodule

// File: rtl/frame_uart_tx.sv
// frame_uart_tx: FIFO-buffered 8N1 UART transmitter for the decoded frame byte stream
module frame_uart_tx
  import frame_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int ADDR_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      din,
  input  logic            den,
  output logic            txd,
  output logic            busy,
  output logic            ovf,
  output logic [ADDR_W:0] level
);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
  logic [1:0] state;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, rdata;
  logic full, empty, pop, baud_end;
  assign pop      = (state == ST_IDLE) & ~empty;
  assign baud_end = baud_cnt == BAUD_LAST;
  assign busy     = (state != ST_IDLE) | ~empty;
  frame_uart_tx_byte_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (den),
    .wdata (din),
    .rd    (pop),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      if (den & full) ovf <= 1'b1;
      baud_cnt <= (state == ST_IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
      case (state)
        ST_IDLE: if (pop) begin
          shift <= rdata;
          txd   <= 1'b0;
          state <= ST_START;
        end
        ST_START: if (baud_end) begin
          txd     <= shift[0];
          bit_cnt <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: if (baud_end) begin
          if (bit_cnt == BIT_LAST) begin
            txd   <= 1'b1;
            state <= ST_STOP;
          end else begin
            shift   <= shift >> 1;
            txd     <= shift[1];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: if (baud_end) state <= ST_IDLE;
      endcase
    end
  end
endmodule
